// File: rtl/room_pkg.sv
// Shared types and defaults for the room door arbiter.
// State encoding and default sizing constants.
package room_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_e;

  localparam int DEF_N           = 4;
  localparam int DEF_DOOR_CYCLES = 3;

endpackage

// File: rtl/room_door_if.sv
// Door bus between request sensors and the arbiter.
// Sensors drive req; the arbiter drives everything else.
interface room_door_if
  import room_pkg::*;
#(
  parameter int N = DEF_N
);
  localparam int CNTW = $clog2(N + 1);

  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            door_open;
  logic [N-1:0]    entered;
  logic [CNTW-1:0] entered_cnt;
  logic            all_in;
  logic            busy;

  modport master (
    output req,
    input  grant, door_open, entered,
    input  entered_cnt, all_in, busy
  );

  modport slave (
    input  req,
    output grant, door_open, entered,
    output entered_cnt, all_in, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// First set mask bit at or above ptr, wrapping mod N.
module rr_arbiter
  import room_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] pick_o,
  output logic [W-1:0] idx_o
);

  logic [W:0]   sum;
  logic [W-1:0] j;

  // Scan from lowest priority to highest so the
  // highest-priority hit is the last one written.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    sum    = '0;
    j      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      j = sum[W-1:0];
      if (mask_i[j]) begin
        pick_o    = '0;
        pick_o[j] = 1'b1;
        idx_o     = j;
      end
    end
  end

endmodule

// File: rtl/room_door_arbiter.sv
// Round-robin door arbiter: one person per opening,
// tracks who is inside and auto-clears each full batch.
module room_door_arbiter
  import room_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input logic        clk,
  input logic        rst_in,
  room_door_if.slave bus
);

  localparam int W    = (N > 1) ? $clog2(N) : 1;
  localparam int CW   = (DOOR_CYCLES > 1) ?
                        $clog2(DOOR_CYCLES) : 1;
  localparam int CNTW = $clog2(N + 1);

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic            door_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    ptr_q;
  logic [W-1:0]    ptr_d;
  logic [N-1:0]    entered_q;
  logic [CNTW-1:0] ecnt_q;

  logic [N-1:0]    eligible;
  logic [N-1:0]    pick;
  logic [W-1:0]    pick_idx;

  assign eligible = bus.req & ~entered_q;

  rr_arbiter #(.N(N)) u_rr (
    .mask_i (eligible),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  assign ptr_d = (pick_idx == W'(N - 1)) ?
                 '0 : pick_idx + W'(1);

  // Door FSM with registered grant, counter, pointer
  // and entry record.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      door_q    <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      entered_q <= '0;
      ecnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q <= OPEN;
            grant_q <= pick;
            door_q  <= 1'b1;
            cnt_q   <= CW'(DOOR_CYCLES - 1);
            ptr_q   <= ptr_d;
          end
        end
        OPEN: begin
          if (cnt_q == '0) begin
            state_q   <= CLOSE;
            entered_q <= entered_q | grant_q;
            ecnt_q    <= ecnt_q + CNTW'(1);
            grant_q   <= '0;
            door_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CLOSE: begin
          state_q <= IDLE;
          if (&entered_q) begin
            entered_q <= '0;
            ecnt_q    <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          door_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.door_open   = door_q;
  assign bus.entered     = entered_q;
  assign bus.entered_cnt = ecnt_q;
  assign bus.all_in      = (state_q == CLOSE) &&
                           (&entered_q);
  assign bus.busy        = (state_q != IDLE);

endmodule
